// File: rtl/adpcm_stream_ctrl.sv
// adpcm_stream_ctrl: clocks the CIC/ADPCM compressor, packs its 4-bit codes into bytes, buffers them in a FIFO
module adpcm_stream_ctrl #(
    parameter int PDM_DIV    = 4,
    parameter int DECIM      = 64,
    parameter int WARMUP     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    output logic       cic_clk,
    output logic       cic_slow_clk,
    output logic       cic_en,
    input  logic       out_valid_i,
    input  logic [3:0] enc_pcm_i,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       busy,
    output logic       overflow
);
    localparam int DW = PDM_DIV > 1 ? $clog2(PDM_DIV) : 1;
    localparam int CW = $clog2(DECIM);
    localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(PDM_DIV - 1);
    localparam logic [CW-1:0] DEC_LAST = CW'(DECIM - 1);
    localparam logic [CW-1:0] DEC_HALF = CW'(DECIM / 2);
    localparam logic [7:0]    WARM_N   = 8'(WARMUP);
    localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_DEPTH - 1);
    localparam logic [AW:0]   FULL_N   = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_DRAIN} state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   div_cnt;
    logic [CW-1:0]   dec_cnt, dec_nxt;
    logic [7:0]      warm_cnt;
    logic            ov_q, pend, ev, run, adv, tick, rise, enter, push, pop, accept;
    logic [3:0]      low_nib;
    logic [7:0]      push_data;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return p == PTR_LAST ? '0 : p + 1'b1;
    endfunction

    // Session sequencing: start opens a session, stop closes it (stop wins over start)
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start && !stop) state_nxt = S_WARMUP;
            S_WARMUP: state_nxt = stop ? S_IDLE : (warm_cnt == WARM_N ? S_RUN : S_WARMUP);
            S_RUN:    if (stop) state_nxt = S_DRAIN;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Clocks only advance while the session stays active, so DRAIN and IDLE see them parked at 0
    assign run       = state == S_WARMUP || state == S_RUN;
    assign adv       = run && (state_nxt == S_WARMUP || state_nxt == S_RUN);
    assign tick      = adv && div_cnt == DIV_LAST;
    assign rise      = tick && !cic_clk;
    assign dec_nxt   = !adv ? '0 : rise ? (dec_cnt == DEC_LAST ? '0 : dec_cnt + 1'b1) : dec_cnt;
    assign enter     = state == S_IDLE && state_nxt == S_WARMUP;
    assign ev        = out_valid_i && !ov_q;
    assign push      = pend && ((state == S_RUN && ev) || state == S_DRAIN);
    assign push_data = {state == S_DRAIN ? 4'h0 : enc_pcm_i, low_nib};
    assign pop       = m_valid && m_ready;
    assign accept    = push && (count != FULL_N || pop);
    assign cic_en    = run;
    assign busy      = state != S_IDLE;
    assign m_valid   = count != '0;
    assign m_data    = m_valid ? mem[rd_ptr] : 8'h00;

    // PDM-rate and decimated clock generation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt      <= '0;
            dec_cnt      <= '0;
            cic_clk      <= 1'b0;
            cic_slow_clk <= 1'b0;
        end else begin
            div_cnt      <= (!adv || tick) ? '0 : div_cnt + 1'b1;
            cic_clk      <= adv && (cic_clk ^ tick);
            dec_cnt      <= dec_nxt;
            cic_slow_clk <= adv && dec_nxt < DEC_HALF;
        end
    end

    // State, warmup discard, nibble packing and FIFO bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ov_q     <= 1'b0;
            warm_cnt <= '0;
            pend     <= 1'b0;
            low_nib  <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_nxt;
            ov_q     <= out_valid_i;
            warm_cnt <= enter ? '0 : (state == S_WARMUP && ev) ? warm_cnt + 8'd1 : warm_cnt;
            pend     <= !enter && ((state == S_RUN && ev) ? !pend : (state == S_DRAIN ? 1'b0 : pend));
            low_nib  <= (state == S_RUN && ev && !pend) ? enc_pcm_i : low_nib;
            overflow <= !enter && (overflow || (push && !accept));
            wr_ptr   <= accept ? inc(wr_ptr) : wr_ptr;
            rd_ptr   <= pop ? inc(rd_ptr) : rd_ptr;
            count    <= count + (AW+1)'(accept) - (AW+1)'(pop);
        end
    end

    // FIFO storage; only the occupancy needs reset
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= push_data;
    end
endmodule

// File: tb/tb_adpcm_stream_ctrl.sv
// tb_adpcm_stream_ctrl: randomized directed bench with a session-level reference model
`timescale 1ns/1ps
module tb_adpcm_stream_ctrl;
    localparam int PDM_DIV = 2, DECIM = 8, WARMUP = 2, DEPTH = 4;
    localparam int P_IDLE = 0, P_WARM = 1, P_RUN = 2, P_DRAIN = 3;

    logic       clk = 0, rst_n = 0, start = 0, stop = 0, out_valid_i = 0, m_ready = 0;
    logic [3:0] enc_pcm_i = 0;
    logic       cic_clk, cic_slow_clk, cic_en, m_valid, busy, overflow;
    logic [7:0] m_data;

    adpcm_stream_ctrl #(.PDM_DIV(PDM_DIV), .DECIM(DECIM), .WARMUP(WARMUP), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cic_clk(cic_clk), .cic_slow_clk(cic_slow_clk), .cic_en(cic_en),
        .out_valid_i(out_valid_i), .enc_pcm_i(enc_pcm_i),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    int phase = P_IDLE, wcnt = 0;
    bit pend = 0, ovf = 0, m_ovq = 0;
    logic [3:0] low = 0;
    logic [7:0] q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // advance one clock: update the reference model for the current cycle, then compare outputs
    task automatic step();
        bit ev, pop, push;
        logic [7:0] pb;
        ev = out_valid_i && !m_ovq;
        pop = q.size() != 0 && m_ready;
        push = 0;
        pb = '0;
        if (!rst_n) begin
            phase = P_IDLE; wcnt = 0; pend = 0; low = 0; ovf = 0; q.delete();
        end else begin
            case (phase)
                P_IDLE: if (start && !stop) begin phase = P_WARM; wcnt = 0; pend = 0; ovf = 0; end
                P_WARM: begin
                    if (stop) phase = P_IDLE; else if (wcnt == WARMUP) phase = P_RUN;
                    if (ev) wcnt++;
                end
                P_RUN: begin
                    if (ev && pend) begin push = 1; pb = {enc_pcm_i, low}; pend = 0; end
                    else if (ev) begin low = enc_pcm_i; pend = 1; end
                    if (stop) phase = P_DRAIN;
                end
                default: begin
                    if (pend) begin push = 1; pb = {4'h0, low}; pend = 0; end
                    phase = P_IDLE;
                end
            endcase
            if (pop) begin chk("pop_data", m_data, q[0]); void'(q.pop_front()); end
            if (push) begin if (q.size() < DEPTH) q.push_back(pb); else ovf = 1; end
        end
        m_ovq = rst_n && out_valid_i;
        @(posedge clk); #1; cyc++;
        chk("m_valid", m_valid, q.size() != 0);
        if (q.size() != 0) chk("m_data", m_data, q[0]);
        chk("overflow", overflow, ovf);
        chk("busy", busy, phase != P_IDLE);
        chk("cic_en", cic_en, phase == P_WARM || phase == P_RUN);
        if (phase == P_IDLE || phase == P_DRAIN) chk("clk_hold", {cic_clk, cic_slow_clk}, 0);
    endtask

    task automatic wait_level(input int which, input logic lvl, output int at);
        logic prev, cur;
        bit found;
        found = 0;
        at = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            prev = which ? cic_slow_clk : cic_clk;
            step();
            cur = which ? cic_slow_clk : cic_clk;
            if (prev !== lvl && cur === lvl) begin found = 1; at = cyc; end
        end
        chk("edge_seen", found, 1);
    endtask

    task automatic code_hi(input logic [3:0] c);
        out_valid_i = 1; enc_pcm_i = c; step();
    endtask

    task automatic code_lo(input int gap);
        out_valid_i = 0; enc_pcm_i = 4'($urandom); repeat (1 + gap) step();
    endtask

    task automatic send(input logic [3:0] c);
        code_hi(c); code_lo($urandom_range(0, 2));
    endtask

    task automatic do_start();
        start = 1; step(); start = 0;
    endtask

    task automatic do_stop();
        stop = 1; step(); stop = 0;
    endtask

    task automatic drain();
        m_ready = 1;
        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, n, nc;
        repeat (3) step();
        chk("rst_m_data", m_data, 0);
        chk("rst_outs", {cic_clk, cic_slow_clk, cic_en, m_valid, busy, overflow}, 0);
        rst_n = 1; step();

        do_start();
        chk("busy_after_start", busy, 1);
        chk("en_after_start", cic_en, 1);
        wait_level(0, 1, t0); wait_level(0, 1, t1);
        chk("cic_period", t1 - t0, 2 * PDM_DIV);
        wait_level(1, 1, t0); wait_level(1, 0, t1); wait_level(1, 1, t2);
        chk("slow_high", t1 - t0, PDM_DIV * DECIM);
        chk("slow_period", t2 - t0, 2 * PDM_DIV * DECIM);

        m_ready = 1;
        send(4'd1); send(4'd2); send(4'd3);
        code_hi(4'd4);
        chk("byte_43", m_data, 8'h43);
        chk("byte_43_valid", m_valid, 1);
        code_lo($urandom_range(0, 2));
        send(4'd5);
        code_hi(4'd6);
        chk("byte_65", m_data, 8'h65);
        code_lo(1);

        for (int i = 0; i < 8; i++) begin m_ready = 1'($urandom_range(0, 1)); send(4'($urandom)); end
        drain();
        code_hi(4'hA); code_lo(1);
        code_hi(4'hB);
        chk("byte_BA", m_data, 8'hBA);
        code_lo(1);
        code_hi(4'hC); code_lo(1);
        do_stop();
        step();
        chk("pad_0C", m_data, 8'h0C);
        chk("idle_busy", busy, 0);
        chk("idle_clks", {cic_clk, cic_slow_clk}, 0);
        drain();

        m_ready = 0;
        do_start();
        for (int i = 0; i < 12; i++) send(4'($urandom));
        chk("ovf_set", overflow, 1);
        chk("full_valid", m_valid, 1);
        do_stop(); step(); step();
        chk("ovf_sticky_idle", overflow, 1);
        m_ready = 1;
        n = 0;
        for (int i = 0; i < 10 && m_valid; i++) begin step(); n++; end
        chk("pop_count", n, 4);
        m_ready = 0;
        do_start();
        chk("ovf_clear", overflow, 0);

        for (int i = 0; i < 10; i++) send(4'($urandom));
        send(4'($urandom));
        m_ready = 1;
        code_hi(4'($urandom));
        m_ready = 0;
        chk("full_pop_push_ovf", overflow, 0);
        code_lo(0);
        m_ready = 1;
        n = 0;
        for (int i = 0; i < 10 && m_valid; i++) begin step(); n++; end
        chk("occupancy", n, 4);

        m_ready = 0;
        send(4'($urandom)); send(4'($urandom)); send(4'($urandom));
        rst_n = 0; step(); rst_n = 1;
        chk("rst_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_clks", {cic_clk, cic_slow_clk, cic_en}, 0);
        repeat (5) step();
        chk("no_pad", m_valid, 0);

        do_start();
        send(4'($urandom));
        do_stop();
        chk("warm_stop_idle", busy, 0);
        repeat (3) step();
        chk("warm_stop_nodata", m_valid, 0);

        for (int s = 0; s < 3; s++) begin
            do_start();
            nc = $urandom_range(0, 12);
            for (int i = 0; i < nc; i++) begin m_ready = 1'($urandom_range(0, 1)); send(4'($urandom)); end
            do_stop();
            step(); step();
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
